// File: rtl/output_interface_if.sv
// ---------------------------------------------------------------------------
// output_interface_if
// Bundles the signals between the AES output serializer, the AES core and the
// external byte bus.
//   cipher   [128:1] ciphertext from the AES core, valid while done=1
//   done             one-cycle completion strobe from the AES core
//   dout     [8:1]   current output byte
//   dout_vld         dout holds a valid byte
//   dout_rdy         downstream accepts the byte at this edge
//   last             current byte is the final (16th) byte
//   ready            serializer idle, a new encryption may start
//   ovf              sticky: done arrived while a block was being sent
// Modports:
//   master - the serializer itself (drives the byte bus and status)
//   slave  - the surroundings (core + byte sink)
// ---------------------------------------------------------------------------
interface output_interface_if;
  logic [128:1] cipher;
  logic         done;
  logic [8:1]   dout;
  logic         dout_vld;
  logic         dout_rdy;
  logic         last;
  logic         ready;
  logic         ovf;

  modport master (
    input  cipher, done, dout_rdy,
    output dout, dout_vld, last, ready, ovf
  );

  modport slave (
    output cipher, done, dout_rdy,
    input  dout, dout_vld, last, ready, ovf
  );
endinterface

// File: rtl/output_interface.sv
// ---------------------------------------------------------------------------
// output_interface
// Captures the 128-bit AES ciphertext on the core's done strobe and sends it
// as 16 bytes, MSB byte first, over a valid/ready byte port. ready tells the
// command side when the previous result has fully left the block.
// Ports:
//   clk   - single clock, rising edge
//   rst_  - synchronous active-low reset
//   bus   - output_interface_if.master (cipher/done in, byte bus + status out)
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module output_interface (
  input  logic                      clk,
  input  logic                      rst_,
  output_interface_if.master        bus
);

  typedef enum logic [0:0] {
    S_ID = 1'b0,
    S_TX = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [128:1] shreg_q, shreg_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic         ovf_q,   ovf_d;

  logic [8:1]   dout_s;
  logic         dout_vld_s;
  logic         last_s;
  logic         ready_s;

  // State register: FSM, shift register, byte counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= S_ID;
      shreg_q <= 128'h0;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: load on done when idle, shift one byte per accepted transfer.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_ID: begin
        if (bus.done) begin
          shreg_d = bus.cipher;
          cnt_d   = 4'd0;
          state_d = S_TX;
        end else begin
          state_d = S_ID;
        end
      end
      S_TX: begin
        // dout_vld is always 1 here, so dout_rdy alone decides the transfer.
        if (bus.dout_rdy) begin
          shreg_d = {shreg_q[120:1], 8'h00};
          cnt_d   = cnt_q + 4'd1;  // wraps to 0 after byte 15
          if (cnt_q == 4'd15) begin
            state_d = S_ID;
          end else begin
            state_d = S_TX;
          end
        end else begin
          state_d = S_TX;
        end
        // A strobe while busy is dropped but remembered.
        if (bus.done) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
      end
      default: begin
        state_d = S_ID;
        shreg_d = 128'h0;
        cnt_d   = 4'd0;
        ovf_d   = ovf_q;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    dout_s     = 8'h00;
    dout_vld_s = 1'b0;
    last_s     = 1'b0;
    ready_s    = 1'b1;
    case (state_q)
      S_ID: begin
        dout_s     = 8'h00;
        dout_vld_s = 1'b0;
        last_s     = 1'b0;
        ready_s    = 1'b1;
      end
      S_TX: begin
        dout_s     = shreg_q[128:121];
        dout_vld_s = 1'b1;
        last_s     = (cnt_q == 4'd15);
        ready_s    = 1'b0;
      end
      default: begin
        dout_s     = 8'h00;
        dout_vld_s = 1'b0;
        last_s     = 1'b0;
        ready_s    = 1'b1;
      end
    endcase
  end

  assign bus.dout     = dout_s;
  assign bus.dout_vld = dout_vld_s;
  assign bus.last     = last_s;
  assign bus.ready    = ready_s;
  assign bus.ovf      = ovf_q;

endmodule
